// File: rtl/bp_stall_counter_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : bp_stall_counter_sampler_if
// Description : Valid/ready stream link from the counter sampler to the
//               host-side FIFO.
//                 data      : stream word (header or counter value)
//                 v         : word valid
//                 ready_and : consumer can accept the word this cycle
//                 last      : final word of a frame
//               master = sampler side, slave = FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bp_stall_counter_sampler_if #(
    parameter int WIDTH_P = 32
);
    logic [WIDTH_P-1:0] data;
    logic               v;
    logic               ready_and;
    logic               last;

    modport master (
        output data,
        output v,
        output last,
        input  ready_and
    );

    modport slave (
        input  data,
        input  v,
        input  last,
        output ready_and
    );
endinterface
`default_nettype wire

// File: rtl/bp_stall_counter_sampler.sv
`default_nettype none
// ============================================================================
// Module      : bp_stall_counter_sampler
// Description : Snapshot sequencer for the stall/instruction counter bank.
//               On a periodic timer tick or a host request, the whole bank is
//               captured in one cycle and streamed as one header word (the
//               frame sequence number) followed by NUM_COUNTERS_P counter
//               words.
// Ports       : clk_i, reset_i  - clock, synchronous active-high reset
//               enable_i        - enables the periodic timer
//               interval_i      - sample period in cycles (0 = no periodic)
//               host_req_i      - one-cycle immediate snapshot request
//               counters_i      - packed counter bank, counter k at
//                                 [k*WIDTH_P +: WIDTH_P]
//               clear_o         - one-cycle clear pulse to the bank
//               stream          - valid/ready output link (master)
//               busy_o          - a frame is in progress
//               seq_o           - frames started so far (wraps)
//               dropped_o       - triggers lost while busy (saturates)
// Revision    : 1.0 - initial release
// ============================================================================
module bp_stall_counter_sampler #(
    parameter int WIDTH_P           = 32,
    parameter int NUM_COUNTERS_P    = 36,
    parameter bit CLEAR_ON_SAMPLE_P = 1'b0
) (
    input  wire logic                              clk_i,
    input  wire logic                              reset_i,
    input  wire logic                              enable_i,
    input  wire logic [WIDTH_P-1:0]                interval_i,
    input  wire logic                              host_req_i,
    input  wire logic [NUM_COUNTERS_P*WIDTH_P-1:0] counters_i,
    output logic                                   clear_o,
    bp_stall_counter_sampler_if.master             stream,
    output logic                                   busy_o,
    output logic [WIDTH_P-1:0]                     seq_o,
    output logic [WIDTH_P-1:0]                     dropped_o
);

    localparam int               c_idx_w = (NUM_COUNTERS_P > 1) ? $clog2(NUM_COUNTERS_P) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_COUNTERS_P - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [WIDTH_P-1:0] c_one      = WIDTH_P'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HEADER  = 2'd2,
        S_SEND    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH_P-1:0]   r_timer;
    logic [c_idx_w-1:0]   r_idx;
    logic [WIDTH_P-1:0]   r_snap [NUM_COUNTERS_P];
    logic [WIDTH_P-1:0]   r_hdr;
    logic [WIDTH_P-1:0]   r_seq;
    logic [WIDTH_P-1:0]   r_dropped;

    logic                 w_timer_on;
    logic                 w_timer_fire;
    logic                 w_trigger;
    logic                 w_idx_last;
    logic                 w_v;
    logic                 w_last;
    logic [WIDTH_P-1:0]   w_data;
    logic                 w_clear;

    assign w_timer_on   = enable_i && (interval_i != '0);
    assign w_timer_fire = w_timer_on && (r_timer == (interval_i - c_one));
    // A timer tick and a host request in the same cycle are one trigger.
    assign w_trigger    = w_timer_fire | host_req_i;
    assign w_idx_last   = (r_idx == c_idx_last);

    // Stream outputs are decoded from registered state and snapshot only,
    // so ready_and never reaches v combinationally.
    always_comb begin
        w_state_next = r_state;
        w_v          = 1'b0;
        w_last       = 1'b0;
        w_data       = '0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_clear      = CLEAR_ON_SAMPLE_P;
                w_state_next = S_HEADER;
            end
            S_HEADER: begin
                w_v    = 1'b1;
                w_data = r_hdr;
                if (stream.ready_and) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                w_v    = 1'b1;
                w_data = r_snap[r_idx];
                w_last = w_idx_last;
                if (stream.ready_and && w_idx_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_timer   <= '0;
            r_idx     <= '0;
            r_hdr     <= '0;
            r_seq     <= '0;
            r_dropped <= '0;
        end else begin
            // Timer runs independently of the FSM so backpressure never
            // stretches the sampling period.
            if (w_timer_on) begin
                r_timer <= w_timer_fire ? '0 : (r_timer + c_one);
            end else begin
                r_timer <= '0;
            end

            if (r_state == S_CAPTURE) begin
                r_hdr <= r_seq;
                r_seq <= r_seq + c_one;
            end

            if ((r_state == S_HEADER) && stream.ready_and) begin
                r_idx <= '0;
            end else if ((r_state == S_SEND) && stream.ready_and && !w_idx_last) begin
                r_idx <= r_idx + c_idx_one;
            end

            if (w_trigger && (r_state != S_IDLE) && (r_dropped != '1)) begin
                r_dropped <= r_dropped + c_one;
            end
        end
    end

    // Snapshot storage needs no reset: it is only read after a capture.
    always_ff @(posedge clk_i) begin
        if (r_state == S_CAPTURE) begin
            for (int k = 0; k < NUM_COUNTERS_P; k++) begin
                r_snap[k] <= counters_i[k*WIDTH_P +: WIDTH_P];
            end
        end
    end

    assign stream.v    = w_v;
    assign stream.data = w_data;
    assign stream.last = w_last;
    assign clear_o     = w_clear;
    assign busy_o      = (r_state != S_IDLE);
    assign seq_o       = r_seq;
    assign dropped_o   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_bp_stall_counter_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_stall_counter_sampler
// Description : Directed self-checking bench for bp_stall_counter_sampler.
//               Inputs are driven and outputs sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_stall_counter_sampler;

    localparam int W = 32;
    localparam int N = 36;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           enable_i = 1'b0;
    logic [W-1:0]   interval_i = '0;
    logic           host_req_i = 1'b0;
    logic [N*W-1:0] counters_i;
    logic [N*W-1:0] static_vec;
    logic [N*W-1:0] live_vec;
    logic           live_mode = 1'b0;
    logic           clear_o;
    logic           busy_o;
    logic [W-1:0]   seq_o;
    logic [W-1:0]   dropped_o;

    int             cyc = 0;
    int             n_checks = 0;
    int             n_errors = 0;
    int             clear_q[$];
    logic [W-1:0]   exp_words [N];
    bit             check_data = 1'b1;

    always #5 clk = ~clk;

    bp_stall_counter_sampler_if #(.WIDTH_P(W)) sif ();

    bp_stall_counter_sampler #(
        .WIDTH_P          (W),
        .NUM_COUNTERS_P   (N),
        .CLEAR_ON_SAMPLE_P(1'b1)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .interval_i (interval_i),
        .host_req_i (host_req_i),
        .counters_i (counters_i),
        .clear_o    (clear_o),
        .stream     (sif.master),
        .busy_o     (busy_o),
        .seq_o      (seq_o),
        .dropped_o  (dropped_o)
    );

    assign counters_i = live_mode ? live_vec : static_vec;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter bank model: counter k advances by k+1 per cycle, cleared by clear_o.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (reset_i || clear_o) live_vec[k*W +: W] <= '0;
            else                    live_vec[k*W +: W] <= live_vec[k*W +: W] + W'(k + 1);
        end
    end

    always @(negedge clk) if (clear_o === 1'b1) clear_q.push_back(cyc);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load_static(input int base, input int step);
        for (int k = 0; k < N; k++) begin
            static_vec[k*W +: W] = W'(base + step * k);
            exp_words[k]         = W'(base + step * k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1; enable_i = 1'b0; host_req_i = 1'b0; sif.ready_and = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic pulse_req(output int t);
        @(negedge clk);
        host_req_i = 1'b1;
        t = cyc;
        @(negedge clk);
        host_req_i = 1'b0;
    endtask

    // Receives up to stop_after words of a frame, checking order, framing and
    // hold-while-stalled behaviour.
    task automatic collect_frame(input logic [W-1:0] exp_hdr, input bit stall_mode,
                                 input int inject_at, input int stop_after, input int budget,
                                 output int first_cyc, output int last_cyc);
        int n = 0, waited = 0, phase = 0;
        bit injected = 1'b0;
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
        logic [W-1:0] pd = '0;
        first_cyc = -1; last_cyc = -1;
        while (n < stop_after && waited < budget) begin
            @(negedge clk);
            waited++;
            sif.ready_and = stall_mode ? ((phase % 4) == 0) : 1'b1;
            if (sif.v) phase++;
            host_req_i = 1'b0;
            if (!injected && inject_at >= 0 && n == inject_at && sif.v) begin
                host_req_i = 1'b1;
                injected   = 1'b1;
            end
            if (pv && !pr) begin
                check_eq("hold_v", sif.v, 1'b1);
                check_eq("hold_data", sif.data, pd);
                check_eq("hold_last", sif.last, pl);
            end
            if (sif.v && sif.ready_and) begin
                if (n == 0) begin
                    first_cyc = cyc;
                    check_eq("header", sif.data, exp_hdr);
                    check_eq("header_last", sif.last, 1'b0);
                end else begin
                    if (check_data) check_eq("word", sif.data, exp_words[n-1]);
                    check_eq("word_last", sif.last, (n == N) ? 1'b1 : 1'b0);
                end
                last_cyc = cyc;
                n++;
            end
            pv = sif.v; pr = sif.ready_and; pd = sif.data; pl = sif.last;
        end
        check_eq("frame_words", n, stop_after);
    endtask

    initial begin
        int t, t1, t2, e, f, l, cb;
        sif.ready_and = 1'b0;
        load_static(100, 1);

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_v", sif.v, 1'b0);
        check_eq("rst_last", sif.last, 1'b0);
        check_eq("rst_data", sif.data, 0);
        check_eq("rst_clear", clear_o, 1'b0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_seq", seq_o, 0);
        check_eq("rst_dropped", dropped_o, 0);
        reset_i = 1'b0;

        // 1: single host request, counters 100..135
        cb = clear_q.size();
        pulse_req(t);
        check_eq("cap_busy", busy_o, 1'b1);
        check_eq("cap_v", sif.v, 1'b0);
        check_eq("cap_clear", clear_o, 1'b1);
        collect_frame(0, 1'b0, -1, N + 1, 50, f, l);
        check_eq("t1_first_cycle", f, t + 2);
        check_eq("t1_span", l - f, N);
        check_eq("t1_seq", seq_o, 1);
        @(negedge clk);
        check_eq("t1_idle_busy", busy_o, 1'b0);
        check_eq("t1_idle_v", sif.v, 1'b0);
        check_eq("t1_clear_count", clear_q.size() - cb, 1);
        check_eq("t1_clear_cycle", clear_q[cb], t + 1);

        // 3: backpressure 1 on / 3 off
        do_reset();
        load_static(7000, 3);
        pulse_req(t);
        collect_frame(0, 1'b1, -1, N + 1, 400, f, l);
        check_eq("t3_seq", seq_o, 1);

        // 2: periodic sampling every 200 cycles
        do_reset();
        load_static(5, 2);
        @(negedge clk);
        interval_i = 200; enable_i = 1'b1; e = cyc;
        for (int i = 0; i < 5; i++) begin
            collect_frame(W'(i), 1'b0, -1, N + 1, 400, f, l);
            check_eq("t2_frame_start", f, e + 199 + 200 * i + 2);
        end
        enable_i = 1'b0;
        check_eq("t2_dropped", dropped_o, 0);
        check_eq("t2_seq", seq_o, 5);

        // 4: coincident timer + host request, then a request during SEND
        do_reset();
        load_static(40, 5);
        @(negedge clk);
        interval_i = 5; enable_i = 1'b1; e = cyc;
        repeat (4) @(negedge clk);
        host_req_i = 1'b1;
        @(negedge clk);
        host_req_i = 1'b0; enable_i = 1'b0;
        collect_frame(0, 1'b0, 20, N + 1, 50, f, l);
        check_eq("t4_frame_start", f, e + 4 + 2);
        check_eq("t4_dropped", dropped_o, 1);
        repeat (10) @(negedge clk);
        check_eq("t4_seq", seq_o, 1);
        check_eq("t4_idle_busy", busy_o, 1'b0);

        // 5: clear-on-sample, second frame holds per-interval deltas
        do_reset();
        live_mode = 1'b1;
        cb = clear_q.size();
        pulse_req(t1);
        check_data = 1'b0;
        collect_frame(0, 1'b0, -1, N + 1, 50, f, l);
        repeat (3) @(negedge clk);
        pulse_req(t2);
        for (int k = 0; k < N; k++) exp_words[k] = W'((k + 1) * (t2 - t1 - 1));
        check_data = 1'b1;
        collect_frame(1, 1'b0, -1, N + 1, 50, f, l);
        check_eq("t5_clear_count", clear_q.size() - cb, 2);
        check_eq("t5_clear_cycle_a", clear_q[cb], t1 + 1);
        check_eq("t5_clear_cycle_b", clear_q[cb+1], t2 + 1);
        live_mode = 1'b0;

        // 6: reset in the middle of SEND at idx 10
        do_reset();
        load_static(300, 7);
        pulse_req(t);
        collect_frame(0, 1'b0, 5, 11, 50, f, l);
        @(negedge clk);
        check_eq("t6_pre_v", sif.v, 1'b1);
        check_eq("t6_pre_data", sif.data, exp_words[10]);
        check_eq("t6_pre_dropped", dropped_o, 1);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check_eq("t6_v", sif.v, 1'b0);
        check_eq("t6_busy", busy_o, 1'b0);
        check_eq("t6_seq", seq_o, 0);
        check_eq("t6_dropped", dropped_o, 0);
        pulse_req(t);
        collect_frame(0, 1'b0, -1, N + 1, 50, f, l);
        check_eq("t6_restart_start", f, t + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
